alu_share_arbiter: RTL and testbench

//  Shares one add/sub/max/compare arithmetic unit between two requesters (A, B).

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters (A, B) share one add/sub/max/compare unit.
// Round-robin grant, valid/ready request handshake, one operation in flight,
// registered result returned together with the requester ID.
// Optional build macro: ALU_ARB_SAT_EN (saturating ADD/SUB instead of modular).
module alu_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MAX = 2'b10;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic             id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   rsp_data_q, rsp_data_d;

    logic             gnt_a, gnt_b;
    logic [WIDTH:0]   alu_res;

    // Grant: only in IDLE and out of reset; a tie goes to the side not served last.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_q == S_IDLE && rst_n) begin
            if (a_valid && b_valid) begin
                if (last_grant_q) gnt_a = 1'b1;
                else              gnt_b = 1'b1;
            end else if (a_valid) begin
                gnt_a = 1'b1;
            end else if (b_valid) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Shared arithmetic unit working on the latched operands.
    always_comb begin
        logic [WIDTH:0] xe, ye, sum, diff;
        logic           gt;
        xe      = {1'b0, x_q};
        ye      = {1'b0, y_q};
        sum     = xe + ye;
        diff    = xe - ye;
        gt      = (x_q > y_q);
        alu_res = '0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
`ifdef ALU_ARB_SAT_EN
                if (sum[WIDTH]) alu_res = {1'b0, {WIDTH{1'b1}}};
`endif
            end
            OP_SUB: begin
                alu_res = diff;
`ifdef ALU_ARB_SAT_EN
                if (diff[WIDTH]) alu_res = '0;
`endif
            end
            OP_MAX:  alu_res = gt ? xe : ye;
            default: alu_res = {{WIDTH{1'b0}}, gt};
        endcase
    end

    // Next-state logic: accept in IDLE, compute in EXEC, hold result in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_a) begin
                    op_d         = a_op;
                    x_d          = a_x;
                    y_d          = a_y;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_EXEC;
                end else if (gnt_b) begin
                    op_d         = b_op;
                    x_d          = b_x;
                    y_d          = b_y;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_res;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation and favours A on the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= 2'b00;
            x_q          <= '0;
            y_q          <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter (WIDTH=4): directed vectors, scoreboard queue
// filled on accept, monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, b_valid, a_ready, b_ready;
    logic [1:0]   a_op, b_op;
    logic [W-1:0] a_x, a_y, b_x, b_y;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W:0]   rsp_data;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int fire_cyc = 0;
    bit push_en = 1'b1;
    logic [W:0] exp_a, exp_b;
    logic [W+1:0] sb[$];       // {id, data}
    bit glog[$];               // grant order, 0 = A, 1 = B

    logic prev_stall = 1'b0, prev_valid = 1'b0, prev_id = 1'b0;
    logic [W:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %0d", nm, act);
        end
    endtask

    always @(posedge clk) cyc++;

    // Accept observer and response monitor, both sampled mid-cycle.
    always @(negedge clk) begin
        if (a_valid && a_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            glog.push_back(1'b0);
            if (push_en) sb.push_back({1'b0, exp_a});
        end
        if (b_valid && b_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            glog.push_back(1'b1);
            if (push_en) sb.push_back({1'b1, exp_b});
        end
        if (prev_stall) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, prev_data);
            chk("hold_id", rsp_id, prev_id);
        end
        if (rsp_valid && !prev_valid) chk("latency", cyc - acc_cyc, 2);
        if (rsp_valid && rsp_ready) begin
            fire_cyc = cyc;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got id=%0d data=%0d expected no response", rsp_id, rsp_data);
            end else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e[W+1]);
                chk("rsp_data", rsp_data, e[W:0]);
            end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_valid = rsp_valid;
        prev_data  = rsp_data;
        prev_id    = rsp_id;
    end

    task automatic wait_acc(input int tgt);
        for (int i = 0; i < 40; i++) begin
            if (acc_cnt >= tgt) return;
            @(posedge clk); #1;
        end
        chk("accept_timeout", acc_cnt, tgt);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !rsp_valid) return;
            @(posedge clk); #1;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic set_a(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] e);
        a_op = op; a_x = x; a_y = y; exp_a = e; a_valid = 1'b1;
    endtask

    task automatic set_b(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] e);
        b_op = op; b_x = x; b_y = y; exp_b = e; b_valid = 1'b1;
    endtask

`ifdef ALU_ARB_SAT_EN
    localparam logic [W:0] EXP_ADD98 = 5'b01111;
    localparam logic [W:0] EXP_SUB35 = 5'b00000;
`else
    localparam logic [W:0] EXP_ADD98 = 5'b10001;
    localparam logic [W:0] EXP_SUB35 = 5'b11110;
`endif

    initial begin
        int base;
        a_op = 0; a_x = 0; a_y = 0; b_op = 0; b_x = 0; b_y = 0;
        exp_a = 0; exp_b = 0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        a_valid = 1'b1;          // requests during reset must not be granted
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: A only, ADD 9+8
        set_a(2'b00, 4'd9, 4'd8, EXP_ADD98);
        wait_acc(acc_cnt + 1);
        a_valid = 1'b0;
        drain();

        // 2: B only, SUB 3-5
        set_b(2'b01, 4'd3, 4'd5, EXP_SUB35);
        wait_acc(acc_cnt + 1);
        b_valid = 1'b0;
        drain();

        // 3: both held high, grants alternate A,B,A,B
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        glog.delete();
        base = acc_cnt;
        set_a(2'b10, 4'd6, 4'd12, 5'd12);
        set_b(2'b11, 4'd6, 4'd12, 5'd0);
        wait_acc(base + 1);
        set_a(2'b11, 4'd12, 4'd6, 5'd1);
        wait_acc(base + 4);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("grant0", glog[0], 0);
        chk("grant1", glog[1], 1);
        chk("grant2", glog[2], 0);
        chk("grant3", glog[3], 1);
        drain();

        // 4: back-pressure in RESP with a pending A request
        rsp_ready = 1'b0;
        set_a(2'b00, 4'd1, 4'd2, 5'd3);
        base = acc_cnt;
        wait_acc(base + 1);
        set_a(2'b00, 4'd4, 4'd4, 5'd8);
        for (int i = 0; i < 10 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_a_ready", a_ready, 0);
            chk("stall_b_ready", b_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_acc(base + 2);
        a_valid = 1'b0;
        chk("accept_after_fire", acc_cyc > fire_cyc, 1);
        drain();

        // 5: reset during EXEC drops the operation and restores the A-first tie
        push_en = 1'b0;
        set_a(2'b00, 4'd2, 4'd3, 5'd5);
        wait_acc(acc_cnt + 1);
        a_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_data", rsp_data, 0);
        push_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        glog.delete();
        base = acc_cnt;
        set_a(2'b00, 4'd1, 4'd1, 5'd2);
        set_b(2'b00, 4'd2, 4'd2, 5'd4);
        wait_acc(base + 2);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("tie_after_rst0", glog[0], 0);
        chk("tie_after_rst1", glog[1], 1);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
